// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target that maps bus transfers onto a 16-bit register file.
//   Write: [addr+W][ptr][hi][lo][hi][lo]... -> one reg_we per {hi,lo} pair, pointer auto-increments.
//   Read : [addr+R] -> reg_re at the pointer, data sent hi then lo, pointer auto-increments.
//   SCL/SDA are oversampled on clk (>= 20x SCL); no clock stretching; SDA is open-drain.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   scl_i, sda_i     asynchronous pad inputs
//   sda_o, sda_t     SDA output value (always 0) and tristate (1 = release, 0 = drive low)
//   reg_addr         register pointer presented with reg_we / reg_re
//   reg_wdata        write data {hi,lo}, valid with reg_we
//   reg_we, reg_re   one-cycle write / read strobes
//   reg_rdata        read data, sampled one clk after reg_re
//   busy             high from a matched address ACK until the next START or STOP
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam logic [CNT_W-1:0] BITS_PER_BYTE = CNT_W'(8);

  // Write byte slot: pointer, expecting hi, expecting lo, full pair ready to commit.
  localparam logic [IDX_W-1:0] IDX_PTR  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_HI   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LO   = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_PAIR = IDX_W'(3);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_LOAD,
    TX_BYTE,
    TX_ACK
  } state_e;

  // Open-drain pad: the output value is always low, only the enable moves.
  assign sda_o = 1'b0;

  // ---------------------------------------------------------------------------
  // Synchronisers, 3-sample majority filter and edge history
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync_q, sda_sync_q;
  logic [2:0] scl_win_q, sda_win_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_filt_c, sda_filt_c;

  assign scl_filt_c = (scl_win_q[0] & scl_win_q[1]) | (scl_win_q[0] & scl_win_q[2]) |
                      (scl_win_q[1] & scl_win_q[2]);
  assign sda_filt_c = (sda_win_q[0] & sda_win_q[1]) | (sda_win_q[0] & sda_win_q[2]) |
                      (sda_win_q[1] & sda_win_q[2]);

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_win_q  <= '1;
      sda_win_q  <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_win_q  <= {scl_win_q[1:0], scl_sync_q[1]};
      sda_win_q  <= {sda_win_q[1:0], sda_sync_q[1]};
      scl_prev_q <= scl_filt_c;
      sda_prev_q <= sda_filt_c;
    end
  end

  logic scl_rise_c, scl_fall_c, start_c, stop_c;
  assign scl_rise_c = scl_filt_c & ~scl_prev_q;
  assign scl_fall_c = ~scl_filt_c & scl_prev_q;
  // SDA may only move under a stable-high SCL for a START/STOP condition.
  assign start_c    = scl_filt_c & scl_prev_q & ~sda_filt_c & sda_prev_q;
  assign stop_c     = scl_filt_c & scl_prev_q & sda_filt_c & ~sda_prev_q;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_byte_c;
  logic [IDX_W-1:0] byte_idx_q;
  logic [7:0]       hi_q, lo_q;
  logic [7:0]       tx_sh_q, tx_lo_q;
  logic             tx_lo_sel_q;
  logic             ack_q;
  logic [1:0]       ld_phase_q;
  logic             inc_q;

  assign rx_byte_c = {shift_q[6:0], sda_filt_c};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_idx_q  <= IDX_PTR;
      hi_q        <= '0;
      lo_q        <= '0;
      tx_sh_q     <= '0;
      tx_lo_q     <= '0;
      tx_lo_sel_q <= 1'b0;
      ack_q       <= 1'b0;
      ld_phase_q  <= '0;
      inc_q       <= 1'b0;
      sda_t       <= 1'b1;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;

      // Pointer advances the cycle after a committed write strobe.
      if (inc_q) begin
        reg_addr <= reg_addr + 8'd1;
        inc_q    <= 1'b0;
      end

      if (start_c) begin
        // START or repeated START: drop any partial or unpaired data.
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_t     <= 1'b1;
        busy      <= 1'b0;
      end else if (stop_c) begin
        state_q <= IDLE;
        sda_t   <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
          end

          ADDR: begin
            if (scl_rise_c && bit_cnt_q != BITS_PER_BYTE) begin
              shift_q   <= rx_byte_c;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else if (scl_fall_c && bit_cnt_q == BITS_PER_BYTE) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                sda_t   <= 1'b0;
                busy    <= 1'b1;
                state_q <= ADDR_ACK;
              end else begin
                state_q <= IDLE;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall_c) begin
              sda_t     <= 1'b1;
              bit_cnt_q <= '0;
              if (shift_q[0]) begin
                ld_phase_q <= '0;
                state_q    <= TX_LOAD;
              end else begin
                byte_idx_q <= IDX_PTR;
                state_q    <= RX_BYTE;
              end
            end
          end

          RX_BYTE: begin
            if (scl_rise_c && bit_cnt_q != BITS_PER_BYTE) begin
              shift_q   <= rx_byte_c;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else if (scl_fall_c && bit_cnt_q == BITS_PER_BYTE) begin
              sda_t   <= 1'b0;
              state_q <= RX_ACK;
              case (byte_idx_q)
                IDX_PTR: begin
                  reg_addr   <= shift_q;
                  byte_idx_q <= IDX_HI;
                end
                IDX_HI: begin
                  hi_q       <= shift_q;
                  byte_idx_q <= IDX_LO;
                end
                default: begin
                  lo_q       <= shift_q;
                  byte_idx_q <= IDX_PAIR;
                end
              endcase
            end
          end

          RX_ACK: begin
            // The write only commits once its lo byte ACK has completed.
            if (scl_fall_c) begin
              sda_t     <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= RX_BYTE;
              if (byte_idx_q == IDX_PAIR) begin
                reg_wdata  <= {hi_q, lo_q};
                reg_we     <= 1'b1;
                inc_q      <= 1'b1;
                byte_idx_q <= IDX_HI;
              end
            end
          end

          TX_LOAD: begin
            // Phase 0 strobes reg_re, phase 1 lets the file respond, phase 2 captures.
            case (ld_phase_q)
              2'd0: begin
                reg_re     <= 1'b1;
                ld_phase_q <= 2'd1;
              end
              2'd1: begin
                ld_phase_q <= 2'd2;
              end
              default: begin
                tx_sh_q     <= reg_rdata[15:8];
                tx_lo_q     <= reg_rdata[7:0];
                tx_lo_sel_q <= 1'b0;
                sda_t       <= reg_rdata[15];
                bit_cnt_q   <= CNT_W'(1);
                state_q     <= TX_BYTE;
              end
            endcase
          end

          TX_BYTE: begin
            if (scl_fall_c) begin
              if (bit_cnt_q == BITS_PER_BYTE) begin
                sda_t   <= 1'b1;
                state_q <= TX_ACK;
              end else begin
                tx_sh_q   <= {tx_sh_q[6:0], 1'b0};
                sda_t     <= tx_sh_q[6];
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
          end

          TX_ACK: begin
            if (scl_rise_c) begin
              ack_q <= ~sda_filt_c;
            end else if (scl_fall_c) begin
              if (!ack_q) begin
                state_q <= IDLE;
              end else if (!tx_lo_sel_q) begin
                tx_sh_q     <= tx_lo_q;
                tx_lo_sel_q <= 1'b1;
                sda_t       <= tx_lo_q[7];
                bit_cnt_q   <= CNT_W'(1);
                state_q     <= TX_BYTE;
              end else begin
                reg_addr   <= reg_addr + 8'd1;
                ld_phase_q <= '0;
                state_q    <= TX_LOAD;
              end
            end
          end

          default: begin
            state_q <= IDLE;
            sda_t   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
